// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the UART transmit feeder
package uart_pkg;

  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - circular byte FIFO with separate count and sticky overflow
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [7:0]        push_byte_i,
  input  logic              pop_i,
  output logic [7:0]        head_byte_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign head_byte_o = mem_q[rd_ptr_q];

  // A pop in the same edge frees a slot, so a full FIFO still accepts the write.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_i && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_byte_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues bytes and launches them one at a time into the UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            i_Clock,
  input  logic            i_Rst_n,
  input  logic            i_Wr_DV,
  input  logic [7:0]      i_Wr_Byte,
  output logic            o_Full,
  output logic            o_Empty,
  output logic [ADDR_W:0] o_Count,
  output logic            o_Overflow,
  output logic            o_Busy,
  output logic            o_Tx_DV,
  output logic [7:0]      o_Tx_Byte,
  input  logic            i_Tx_Active,
  input  logic            i_Tx_Done
);

  feeder_state_e state_q, state_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          launch;
  logic [7:0]    head_byte;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i       (i_Clock),
    .rst_ni      (i_Rst_n),
    .push_i      (i_Wr_DV),
    .push_byte_i (i_Wr_Byte),
    .pop_i       (launch),
    .head_byte_o (head_byte),
    .full_o      (o_Full),
    .empty_o     (o_Empty),
    .count_o     (o_Count),
    .overflow_o  (o_Overflow)
  );

  // The idle guard also covers a transmitter still finishing a byte from before a feeder reset.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    launch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
          launch    = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = head_byte;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: if (i_Tx_Active) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_Tx_Done)   state_d = S_GAP;
      S_GAP:       if (!i_Tx_Done)  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Busy    = (state_q != S_IDLE);
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

endmodule
